// File: rtl/ext_mem_pkg.sv
// Shared types and command-word layout for the external memory bus model.
package ext_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_WRITE,
        ST_READ,
        ST_TURN
    } state_t;

    // Field positions measured from the top of the command word
    localparam int CMD_DIR_FROM_MSB = 0;
    localparam int CMD_LEN_FROM_MSB = 1;
    localparam int CMD_ADDR_LSB     = 0;
    localparam int WAIT_CNT_W       = 4;

endpackage

// File: rtl/ext_mem_bus_model_if.sv
// Controller <-> memory-model bus: command/write data in, registered read data out.
interface ext_mem_bus_model_if #(
    parameter int DATA_W = 32
);
    logic              en;
    logic [DATA_W-1:0] bus_i;
    logic [DATA_W-1:0] bus_o;
    logic              bus_oe;
    logic              busy;
    logic              aborted;

    modport master (output en, bus_i, input bus_o, bus_oe, busy, aborted);
    modport slave  (input en, bus_i, output bus_o, bus_oe, busy, aborted);
endinterface

// File: rtl/ext_mem_bus_model.sv
// Behavioural external memory: command word, programmable wait, then a write
// or read burst with address wrap, early abort on en low and read turnaround.
module ext_mem_bus_model
    import ext_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 3,
    parameter int LEN_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    ext_mem_bus_model_if.slave mb
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int DIR_BIT = DATA_W - 1 - CMD_DIR_FROM_MSB;
    localparam int LEN_MSB = DATA_W - 1 - CMD_LEN_FROM_MSB;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t                state, state_n;
    logic [ADDR_W-1:0]     addr, addr_n;
    logic [LEN_W-1:0]      left, left_n;
    logic [WAIT_CNT_W-1:0] cnt, cnt_n;
    logic                  dir, dir_n;
    logic                  oe_n, abort_n;
    logic                  wr_fire, rd_fire;
    logic [DATA_W-1:0]     bus_o_q;
    logic                  bus_oe_q, aborted_q;

    assign mb.bus_o   = bus_o_q;
    assign mb.bus_oe  = bus_oe_q;
    assign mb.aborted = aborted_q;
    assign mb.busy    = (state != ST_IDLE);

    always_comb begin
        state_n = state;
        addr_n  = addr;
        left_n  = left;
        cnt_n   = cnt;
        dir_n   = dir;
        oe_n    = 1'b0;
        abort_n = 1'b0;
        wr_fire = 1'b0;
        rd_fire = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (mb.en) begin
                    addr_n  = mb.bus_i[CMD_ADDR_LSB +: ADDR_W];
                    left_n  = mb.bus_i[LEN_MSB -: LEN_W];
                    dir_n   = mb.bus_i[DIR_BIT];
                    cnt_n   = WAIT_CNT_W'(WAIT_CYCLES);
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!mb.en) begin
                    state_n = ST_IDLE;
                    abort_n = 1'b1;
                    cnt_n   = '0;
                end else if (cnt == '0) begin
                    state_n = dir ? ST_WRITE : ST_READ;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_WRITE: begin
                if (!mb.en) begin
                    state_n = ST_IDLE;
                    abort_n = 1'b1;
                end else begin
                    wr_fire = 1'b1;
                    addr_n  = addr + 1'b1;
                    left_n  = left - 1'b1;
                    if (left == '0) state_n = ST_IDLE;
                end
            end
            ST_READ: begin
                // An abort still passes through TURN so the bus gets its gap
                if (!mb.en) begin
                    state_n = ST_TURN;
                    abort_n = 1'b1;
                end else begin
                    rd_fire = 1'b1;
                    oe_n    = 1'b1;
                    addr_n  = addr + 1'b1;
                    left_n  = left - 1'b1;
                    if (left == '0) state_n = ST_TURN;
                end
            end
            ST_TURN: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            left      <= '0;
            cnt       <= '0;
            dir       <= 1'b0;
            bus_o_q   <= '0;
            bus_oe_q  <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            left      <= left_n;
            cnt       <= cnt_n;
            dir       <= dir_n;
            bus_oe_q  <= oe_n;
            aborted_q <= abort_n;
            if (rd_fire) bus_o_q <= mem[addr];
        end
    end

    // Storage is deliberately never reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (wr_fire) mem[addr] <= mb.bus_i;
    end

endmodule

// File: tb/tb_ext_mem_bus_model.sv
// Randomized bench for ext_mem_bus_model: two parameterisations driven from a
// transaction-level model with a per-cycle compare of busy/bus_oe/aborted/bus_o.
module tb_ext_mem_bus_model;

    localparam int DW_A = 32, AW_A = 20, W_A = 3, DEP_A = 2 ** AW_A;
    localparam int DW_B = 64, AW_B = 10, W_B = 0, DEP_B = 2 ** AW_B;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_drv = 1'b0;
    logic        sel = 1'b0;
    logic [63:0] din = '0;

    int total = 0;
    int bad = 0;

    logic        eb [2];
    logic        eo [2];
    logic        ea [2];
    logic [63:0] ed [2];
    logic [63:0] mdl [int];
    logic [63:0] wdat [$];
    logic [63:0] cap_q [$];
    int          ecnt;
    int          first_oe;

    always #5 clk = ~clk;

    ext_mem_bus_model_if #(.DATA_W(DW_A)) ifa ();
    ext_mem_bus_model_if #(.DATA_W(DW_B)) ifb ();

    assign ifa.en    = en_drv & ~sel;
    assign ifa.bus_i = din[DW_A-1:0];
    assign ifb.en    = en_drv & sel;
    assign ifb.bus_i = din;

    ext_mem_bus_model #(.DATA_W(DW_A), .ADDR_W(AW_A), .WAIT_CYCLES(W_A), .LEN_W(LW))
        dut_a (.clk(clk), .rst_n(rst_n), .mb(ifa));
    ext_mem_bus_model #(.DATA_W(DW_B), .ADDR_W(AW_B), .WAIT_CYCLES(W_B), .LEN_W(LW))
        dut_b (.clk(clk), .rst_n(rst_n), .mb(ifb));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a_busy", 64'(ifa.busy), 64'(eb[0]));
        chk("a_oe", 64'(ifa.bus_oe), 64'(eo[0]));
        chk("a_aborted", 64'(ifa.aborted), 64'(ea[0]));
        if (eo[0]) chk("a_rdata", 64'(ifa.bus_o), ed[0]);
        chk("b_busy", 64'(ifb.busy), 64'(eb[1]));
        chk("b_oe", 64'(ifb.bus_oe), 64'(eo[1]));
        chk("b_aborted", 64'(ifb.aborted), 64'(ea[1]));
        if (eo[1]) chk("b_rdata", ifb.bus_o, ed[1]);
    end

    function automatic int key(input bit s, input int a);
        return (s ? 32'h0100_0000 : 0) + a;
    endfunction

    function automatic logic [63:0] msk(input bit s, input logic [63:0] v);
        return s ? v : {32'h0, v[31:0]};
    endfunction

    function automatic logic [63:0] rnd(input bit s);
        return msk(s, {$urandom, $urandom});
    endfunction

    function automatic logic [63:0] enc(input bit s, input bit dir, input int len, input int addr);
        logic [63:0] c;
        int dw;
        dw = s ? DW_B : DW_A;
        c = '0;
        c[dw-1] = dir;
        c = c | (64'(len - 1) << (dw - 1 - LW));
        c = c | 64'(addr);
        return c;
    endfunction

    function automatic logic [63:0] getmem(input bit s, input int a);
        if (s) return dut_b.mem[a[AW_B-1:0]];
        return 64'(dut_a.mem[a[AW_A-1:0]]);
    endfunction

    task automatic set_exp(input bit s, input logic b, input logic o, input logic a,
                           input logic [63:0] d);
        eb[s] = b;
        eo[s] = o;
        ea[s] = a;
        ed[s] = d;
    endtask

    task automatic drive(input logic e, input logic [63:0] d);
        en_drv = e;
        din = d;
        @(posedge clk);
        #1;
        ecnt++;
        if (sel ? ifb.bus_oe : ifa.bus_oe) begin
            cap_q.push_back(sel ? ifb.bus_o : 64'(ifa.bus_o));
            if (first_oe < 0) first_oe = ecnt - 1;
        end
    endtask

    task automatic idle(input bit s);
        drive(1'b0, rnd(s));
        set_exp(s, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // wab: WAIT edge to drop en on, bab: beat to drop en on, rab: beat to reset on
    task automatic do_txn(input bit s, input bit dir, input int len, input int addr,
                          input int wab, input int bab, input int rab);
        int w, dep, a;
        logic [63:0] d;
        w = s ? W_B : W_A;
        dep = s ? DEP_B : DEP_A;
        cap_q.delete();
        first_oe = -1;
        ecnt = 0;
        sel = s;
        drive(1'b1, enc(s, dir, len, addr));
        set_exp(s, 1'b1, 1'b0, 1'b0, '0);
        for (int j = 0; j <= w; j++) begin
            if (j == wab) begin
                drive(1'b0, rnd(s));
                set_exp(s, 1'b0, 1'b0, 1'b1, '0);
                idle(s);
                wdat.delete();
                return;
            end
            drive(1'b1, rnd(s));
            set_exp(s, 1'b1, 1'b0, 1'b0, '0);
        end
        for (int k = 0; k < len; k++) begin
            a = (addr + k) % dep;
            if (k == rab) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", 64'(s ? ifb.busy : ifa.busy), 64'd0);
                chk("rst_oe", 64'(s ? ifb.bus_oe : ifa.bus_oe), 64'd0);
                chk("rst_aborted", 64'(s ? ifb.aborted : ifa.aborted), 64'd0);
                chk("rst_bus_o", s ? ifb.bus_o : 64'(ifa.bus_o), 64'd0);
                set_exp(s, 1'b0, 1'b0, 1'b0, '0);
                repeat (2) @(negedge clk);
                #2 rst_n = 1'b1;
                idle(s);
                wdat.delete();
                return;
            end
            if (k == bab) begin
                drive(1'b0, rnd(s));
                set_exp(s, !dir, 1'b0, 1'b1, '0);
                if (!dir) begin
                    drive(1'($urandom_range(0, 1)), rnd(s));
                    set_exp(s, 1'b0, 1'b0, 1'b0, '0);
                end
                idle(s);
                wdat.delete();
                return;
            end
            if (dir) begin
                if (wdat.size() > 0) d = wdat.pop_front();
                else d = rnd(s);
                drive(1'b1, d);
                mdl[key(s, a)] = msk(s, d);
                set_exp(s, k < len - 1, 1'b0, 1'b0, '0);
            end else begin
                drive(1'b1, rnd(s));
                set_exp(s, 1'b1, 1'b1, 1'b0, mdl[key(s, a)]);
            end
        end
        if (!dir) begin
            drive(1'($urandom_range(0, 1)), rnd(s));
            set_exp(s, 1'b0, 1'b0, 1'b0, '0);
        end
        idle(s);
        wdat.delete();
    endtask

    initial begin
        int dep, base, len, addr, w, r, wab, bab;
        bit s, dir;
        for (int i = 0; i < 2; i++) set_exp(1'(i), 1'b0, 1'b0, 1'b0, '0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_busy", 64'(ifa.busy), 64'd0);
        chk("reset_a_oe", 64'(ifa.bus_oe), 64'd0);
        chk("reset_a_bus_o", 64'(ifa.bus_o), 64'd0);
        chk("reset_b_aborted", 64'(ifb.aborted), 64'd0);
        chk("reset_b_bus_o", ifb.bus_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Window preload: mem[a] = a for a in 0..79 and DEPTH-16..DEPTH-1
        for (int si = 0; si < 2; si++) begin
            dep = si ? DEP_B : DEP_A;
            for (int b = 0; b < 6; b++) begin
                base = (b < 5) ? b * 16 : dep - 16;
                for (int k = 0; k < 16; k++) wdat.push_back(64'(base + k));
                do_txn(1'(si), 1'b1, 16, base, -1, -1, -1);
            end
        end

        chk("enc_write4", enc(1'b0, 1'b1, 4, 'h10), 64'h9800_0010);
        chk("enc_read4", enc(1'b0, 1'b0, 4, 'h10), 64'h1800_0010);

        for (int si = 0; si < 2; si++) begin
            dep = si ? DEP_B : DEP_A;
            wdat = '{64'hA, 64'hB, 64'hC, 64'hD};
            do_txn(1'(si), 1'b1, 4, 'h10, -1, -1, -1);
            for (int k = 0; k < 4; k++) chk("wr_burst_mem", getmem(1'(si), 'h10 + k), 64'('hA + k));
            do_txn(1'(si), 1'b0, 4, 'h10, -1, -1, -1);
            chk("rd_burst_beats", 64'(cap_q.size()), 64'd4);
            for (int k = 0; k < cap_q.size(); k++) chk("rd_burst_data", cap_q[k], 64'('hA + k));
            chk("rd_latency", 64'(first_oe), si ? 64'd2 : 64'd5);
            wdat = '{64'h11, 64'h22};
            do_txn(1'(si), 1'b1, 2, dep - 1, -1, -1, -1);
            chk("wrap_top", getmem(1'(si), dep - 1), 64'h11);
            chk("wrap_zero", getmem(1'(si), 0), 64'h22);
        end

        do_txn(1'b0, 1'b0, 8, 'h20, -1, 3, -1);
        chk("abort_beats", 64'(cap_q.size()), 64'd3);
        for (int k = 0; k < cap_q.size(); k++) chk("abort_data", cap_q[k], 64'('h20 + k));
        do_txn(1'b0, 1'b0, 3, 'h30, 1, -1, -1);
        chk("wait_abort_beats", 64'(cap_q.size()), 64'd0);

        wdat = '{64'h77, 64'h88, 64'h99, 64'hAA};
        do_txn(1'b0, 1'b1, 4, 'h40, -1, -1, 2);
        chk("rst_wr_w0", getmem(1'b0, 'h40), 64'h77);
        chk("rst_wr_w1", getmem(1'b0, 'h41), 64'h88);
        chk("rst_wr_keep2", getmem(1'b0, 'h42), 64'h42);
        chk("rst_wr_keep3", getmem(1'b0, 'h43), 64'h43);
        do_txn(1'b0, 1'b0, 4, 'h24, -1, -1, 2);
        chk("rst_rd_beats", 64'(cap_q.size()), 64'd2);
        do_txn(1'b0, 1'b0, 4, 'h40, -1, -1, -1);
        chk("after_rst_beats", 64'(cap_q.size()), 64'd4);
        if (cap_q.size() == 4) chk("after_rst_data", cap_q[3], 64'h43);

        for (int n = 0; n < 60; n++) begin
            s = 1'($urandom_range(0, 1));
            dir = 1'($urandom_range(0, 1));
            dep = s ? DEP_B : DEP_A;
            w = s ? W_B : W_A;
            len = $urandom_range(1, 16);
            addr = ($urandom_range(0, 63) + dep - 8) % dep;
            r = $urandom_range(0, 9);
            wab = (r == 0) ? $urandom_range(0, w) : -1;
            bab = (r == 1) ? $urandom_range(0, len - 1) : -1;
            do_txn(s, dir, len, addr, wab, bab, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
